// File: rtl/hfosc_pkg.sv
// Shared types for the HF oscillator sequencer: FSM states, counter width, output decode.
package hfosc_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      S_OFF     = 3'd0,
      S_PWRUP   = 3'd1,
      S_SETTLE  = 3'd2,
      S_ON      = 3'd3,
      S_DISABLE = 3'd4
   } state_t;

   typedef struct packed {
      logic pu;
      logic en;
      logic ready;
      logic busy;
   } outs_t;

   // Pin levels for a state; anything unexpected decodes to all-off.
   function automatic outs_t decode(input state_t s);
      outs_t o;
      o = '0;
      case (s)
         S_PWRUP:   begin o.pu = 1'b1; o.busy = 1'b1; end
         S_SETTLE:  begin o.pu = 1'b1; o.en = 1'b1; o.busy = 1'b1; end
         S_ON:      begin o.pu = 1'b1; o.en = 1'b1; o.ready = 1'b1; end
         S_DISABLE: begin o.pu = 1'b1; o.busy = 1'b1; end
         default:   o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/hfosc_dly_cnt.sv
// Loadable 16-bit down-counter that saturates at zero; zero is combinational from the count.
// Load wins over decrement; no flow control.
module hfosc_dly_cnt
   import hfosc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - CNT_W'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/hfosc_seq.sv
// HF oscillator power sequencer: PU before EN, EN dropped before PU; outputs registered on state entry.
// Request-to-ready latency 1+PU_CYCLES+EN_CYCLES edges; osc_req is a level, no backpressure.
module hfosc_seq
   import hfosc_pkg::*;
#(
   parameter int unsigned PU_CYCLES  = 4,
   parameter int unsigned EN_CYCLES  = 2,
   parameter int unsigned DIS_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       osc_req,
   output logic       osc_pu,
   output logic       osc_en,
   output logic       osc_ready,
   output logic       busy,
   output logic [2:0] state
);

   localparam logic [CNT_W-1:0] PU_LD  = CNT_W'(PU_CYCLES - 1);
   localparam logic [CNT_W-1:0] EN_LD  = CNT_W'(EN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIS_LD = CNT_W'(DIS_CYCLES - 1);

   state_t           st;
   outs_t            outs;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             zero;

   // Counter reloads mirror the FSM transitions below.
   always_comb begin
      load     = 1'b0;
      load_val = '0;
      case (st)
         S_OFF:    if (osc_req)          begin load = 1'b1; load_val = PU_LD;  end
         S_PWRUP:  if (osc_req && zero)  begin load = 1'b1; load_val = EN_LD;  end
         S_SETTLE,
         S_ON:     if (!osc_req)         begin load = 1'b1; load_val = DIS_LD; end
         default:  ;
      endcase
   end

   hfosc_dly_cnt u_dly_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .zero     (zero)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st   <= S_OFF;
         outs <= '0;
      end else begin
         case (st)
            S_OFF:
               if (osc_req) begin
                  st <= S_PWRUP;  outs <= decode(S_PWRUP);
               end
            // EN was never raised here, so an abort can drop PU at once.
            S_PWRUP:
               if (!osc_req) begin
                  st <= S_OFF;    outs <= decode(S_OFF);
               end else if (zero) begin
                  st <= S_SETTLE; outs <= decode(S_SETTLE);
               end
            S_SETTLE:
               if (!osc_req) begin
                  st <= S_DISABLE; outs <= decode(S_DISABLE);
               end else if (zero) begin
                  st <= S_ON;      outs <= decode(S_ON);
               end
            S_ON:
               if (!osc_req) begin
                  st <= S_DISABLE; outs <= decode(S_DISABLE);
               end
            S_DISABLE:
               if (zero) begin
                  st <= S_OFF;    outs <= decode(S_OFF);
               end
            default: begin
               st   <= S_OFF;
               outs <= '0;
            end
         endcase
      end
   end

   assign osc_pu    = outs.pu;
   assign osc_en    = outs.en;
   assign osc_ready = outs.ready;
   assign busy      = outs.busy;
   assign state     = st;

endmodule

// File: tb/tb_hfosc_seq.sv
// Directed bench for hfosc_seq: default instance (a) plus a PU=1/EN=1 instance (b), shared clk/reset.
module tb_hfosc_seq;

   // Output vector {pu, en, ready, busy, state[2:0]}.
   localparam logic [6:0] X_OFF = 7'h00;
   localparam logic [6:0] X_PW  = 7'h49;
   localparam logic [6:0] X_SE  = 7'h6A;
   localparam logic [6:0] X_ON  = 7'h73;
   localparam logic [6:0] X_DIS = 7'h4C;

   logic       clk;
   logic       rst_n;
   logic       req_a, req_b;
   logic       pu_a, en_a, rdy_a, busy_a;
   logic       pu_b, en_b, rdy_b, busy_b;
   logic [2:0] st_a, st_b;
   logic       inv_on;
   int         n_chk;
   int         n_err;

   wire [6:0] obs_a = {pu_a, en_a, rdy_a, busy_a, st_a};
   wire [6:0] obs_b = {pu_b, en_b, rdy_b, busy_b, st_b};

   hfosc_seq u_dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .osc_req   (req_a),
      .osc_pu    (pu_a),
      .osc_en    (en_a),
      .osc_ready (rdy_a),
      .busy      (busy_a),
      .state     (st_a)
   );

   hfosc_seq #(.PU_CYCLES(1), .EN_CYCLES(1), .DIS_CYCLES(2)) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .osc_req   (req_b),
      .osc_pu    (pu_b),
      .osc_en    (en_b),
      .osc_ready (rdy_b),
      .busy      (busy_b),
      .state     (st_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input logic [6:0] ea, input logic [6:0] eb);
      @(posedge clk);
      #1;
      check(tag, {25'd0, obs_a}, {25'd0, ea});
      check({tag, "_b"}, {25'd0, obs_b}, {25'd0, eb});
   endtask

   // Full power-up on instance a from OFF; b held off.
   task automatic power_up_a(input string tag);
      req_a = 1'b1;
      step({tag, "_pw1"}, X_PW,  X_OFF);
      step({tag, "_pw2"}, X_PW,  X_OFF);
      step({tag, "_pw3"}, X_PW,  X_OFF);
      step({tag, "_pw4"}, X_PW,  X_OFF);
      step({tag, "_se1"}, X_SE,  X_OFF);
      step({tag, "_se2"}, X_SE,  X_OFF);
      step({tag, "_on"},  X_ON,  X_OFF);
   endtask

   // Pin-level invariants on both instances every cycle.
   always @(negedge clk) begin
      if (inv_on) begin
         check("inv_en_pu_a",  {31'd0, en_a & ~pu_a}, 32'd0);
         check("inv_rdy_en_a", {31'd0, rdy_a & ~en_a}, 32'd0);
         check("inv_busy_a",   {31'd0, busy_a},
               {31'd0, (st_a == 3'd1) || (st_a == 3'd2) || (st_a == 3'd4)});
         check("inv_en_pu_b",  {31'd0, en_b & ~pu_b}, 32'd0);
         check("inv_rdy_en_b", {31'd0, rdy_b & ~en_b}, 32'd0);
         check("inv_busy_b",   {31'd0, busy_b},
               {31'd0, (st_b == 3'd1) || (st_b == 3'd2) || (st_b == 3'd4)});
      end
   end

   initial begin
      n_chk  = 0;
      n_err  = 0;
      inv_on = 1'b0;
      rst_n  = 1'b0;
      req_a  = 1'b1;
      req_b  = 1'b1;

      // Reset held with request high: both instances stay OFF.
      step("rst", X_OFF, X_OFF);
      inv_on = 1'b1;
      rst_n  = 1'b1;
      req_a  = 1'b0;
      req_b  = 1'b0;
      step("idle1", X_OFF, X_OFF);
      step("idle2", X_OFF, X_OFF);

      power_up_a("up");
      step("on_hold", X_ON, X_OFF);

      // Power-down: EN/ready drop next edge, PU two edges later.
      req_a = 1'b0;
      step("dn_dis1", X_DIS, X_OFF);
      step("dn_dis2", X_DIS, X_OFF);
      step("dn_off",  X_OFF, X_OFF);
      step("dn_off2", X_OFF, X_OFF);

      // PWRUP abort after two cycles.
      req_a = 1'b1;
      step("ab_pw1", X_PW, X_OFF);
      step("ab_pw2", X_PW, X_OFF);
      req_a = 1'b0;
      step("ab_off1", X_OFF, X_OFF);
      step("ab_off2", X_OFF, X_OFF);

      // Request returns during DISABLE: ignored, one OFF cycle, fresh PWRUP.
      power_up_a("rs");
      req_a = 1'b0;
      step("rs_dis1", X_DIS, X_OFF);
      req_a = 1'b1;
      step("rs_dis2", X_DIS, X_OFF);
      step("rs_off",  X_OFF, X_OFF);
      step("rs_pw1",  X_PW,  X_OFF);
      step("rs_pw2",  X_PW,  X_OFF);
      step("rs_pw3",  X_PW,  X_OFF);
      step("rs_pw4",  X_PW,  X_OFF);
      step("rs_se1",  X_SE,  X_OFF);

      // Request drop in SETTLE goes through DISABLE.
      req_a = 1'b0;
      step("sd_dis1", X_DIS, X_OFF);
      step("sd_dis2", X_DIS, X_OFF);
      step("sd_off",  X_OFF, X_OFF);

      // Both instances up together; b reaches ON after 3 edges.
      req_a = 1'b1;
      req_b = 1'b1;
      step("mr_e1", X_PW, X_PW);
      step("mr_e2", X_PW, X_SE);
      step("mr_e3", X_PW, X_ON);
      step("mr_e4", X_PW, X_ON);
      step("mr_e5", X_SE, X_ON);
      step("mr_e6", X_SE, X_ON);
      step("mr_e7", X_ON, X_ON);

      // Reset in ON clears everything on the next edge.
      rst_n = 1'b0;
      step("mr_rst", X_OFF, X_OFF);
      rst_n = 1'b1;
      req_a = 1'b0;
      req_b = 1'b0;
      step("mr_idle", X_OFF, X_OFF);

      // Instance b full cycle with short timings.
      req_b = 1'b1;
      step("b_pw",   X_OFF, X_PW);
      step("b_se",   X_OFF, X_SE);
      step("b_on",   X_OFF, X_ON);
      req_b = 1'b0;
      step("b_dis1", X_OFF, X_DIS);
      step("b_dis2", X_OFF, X_DIS);
      step("b_off",  X_OFF, X_OFF);

      @(posedge clk);
      #1;
      inv_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/hfosc_seq.md
HFOSC_SEQ -- requirements
Module: hfosc_seq

Interface
REQ-001 SHALL have parameter PU_CYCLES, default 4: clk cycles osc_pu is held high with osc_en low before enable (covers ≥100 us oscillator power-up; legal range 1..65535).
REQ-002 SHALL have parameter EN_CYCLES, default 2: clk cycles after osc_en rises before osc_ready asserts (legal range 1..65535).
REQ-003 SHALL have parameter DIS_CYCLES, default 2: clk cycles osc_en is low, with osc_pu still high, before osc_pu drops (legal range 1..65535).
REQ-004 SHALL have port clk, input, 1: always-on slow clock; the only clock.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port osc_req, input, 1: level request for the high-frequency oscillator to run.
REQ-007 SHALL have port osc_pu, output, 1: drives the oscillator power-up pin.
REQ-008 SHALL have port osc_en, output, 1: drives the oscillator output-enable pin.
REQ-009 SHALL have port osc_ready, output, 1: the oscillator clock is stable and usable.
REQ-010 SHALL have port busy, output, 1: high in any transitional state (PWRUP, SETTLE, DISABLE).
REQ-011 SHALL have port state, output, 3: current FSM state encoding, for debug.

Function
REQ-012 SHALL implement states OFF, PWRUP, SETTLE, ON and DISABLE, using one down-counter that is 16 bits wide.
REQ-013 In OFF, outputs SHALL be osc_pu=0, osc_en=0, osc_ready=0; if osc_req=1, the FSM SHALL go to PWRUP and load the counter with PU_CYCLES-1.
REQ-014 In PWRUP, outputs SHALL be osc_pu=1 and osc_en=0; when counter=0, the FSM SHALL go to SETTLE and load EN_CYCLES-1; otherwise it SHALL decrement.
REQ-015 In SETTLE, outputs SHALL be osc_pu=1, osc_en=1, osc_ready=0; when counter=0, the FSM SHALL go to ON.
REQ-016 In ON, outputs SHALL be osc_pu=1, osc_en=1, osc_ready=1; if osc_req=0, the FSM SHALL go to DISABLE and load DIS_CYCLES-1.
REQ-017 In DISABLE, outputs SHALL be osc_pu=1, osc_en=0, osc_ready=0; when counter=0, the FSM SHALL go to OFF.
REQ-018 osc_en SHALL never be 1 unless osc_pu is 1, and SHALL never be 1 within PU_CYCLES cycles of osc_pu rising.
REQ-019 All outputs SHALL be registered, decoded from the registered state, and change exactly on the clk edge that enters the state.
REQ-020 Request drop in PWRUP SHALL send the FSM directly to OFF on the next edge, because osc_en was never asserted.
REQ-021 Request drop in SETTLE SHALL send the FSM to DISABLE and load DIS_CYCLES-1.
REQ-022 Request rise during DISABLE SHALL be ignored until OFF is reached; OFF SHALL then re-enter PWRUP on the next edge, giving a minimum off time of 1 cycle in OFF.
REQ-023 The latency from osc_req=1 sampled in OFF to osc_ready=1 SHALL be 1+PU_CYCLES+EN_CYCLES edges.
REQ-024 The counter SHALL NOT underflow; the transition at 0 takes priority over decrement.
REQ-025 The FSM SHALL use a default branch that recovers any illegal state encoding to OFF with all outputs 0.

Reset
REQ-026 rst_n=0 sampled at a clk edge SHALL force OFF, counter=0, osc_pu=0, osc_en=0, osc_ready=0, busy=0 on that edge, from any state including mid-PWRUP or ON.
REQ-027 Release of reset SHALL NOT start a sequence until osc_req=1 is sampled in OFF.

Structure
REQ-028 The state enumeration and the 16-bit counter width constant SHALL reside in the shared package hfosc_pkg.
REQ-029 The down-counter MAY be factored into the sub-module hfosc_dly_cnt (inputs load, load_val; output zero); the FSM SHALL remain in hfosc_seq.
REQ-030 The outputs SHALL connect directly to the oscillator pins CLKHFPU (osc_pu) and CLKHFEN (osc_en) with no glue logic.

Verification
REQ-031 Power-up test: defaults, reset then osc_req=1 -> osc_pu rises 1 edge later, osc_en rises 4 edges after osc_pu, and osc_ready rises 2 edges after osc_en (7 edges total).
REQ-032 Power-down test: from ON, osc_req=0 -> osc_en and osc_ready fall next edge, osc_pu falls 2 edges later, and state=OFF.
REQ-033 PWRUP abort test: osc_req=1 for 2 cycles then 0 -> osc_pu pulse of 2 cycles, osc_en never high, and return to OFF.
REQ-034 DISABLE restart test: osc_req toggles 1 during DISABLE -> full DISABLE completes, 1 cycle in OFF, then a fresh 4-cycle PWRUP.
REQ-035 Mid-ON reset test: rst_n=0 asserted in ON -> all outputs 0 on the next edge; with PU_CYCLES=1 and EN_CYCLES=1, osc_ready is reached 3 edges after the request.
REQ-036 Assertion check in all tests: osc_en implies osc_pu; busy equals (state in PWRUP, SETTLE or DISABLE); osc_ready implies osc_en.
